sr_dmem: RTL and testbench

SR_DMEM -- requirements
Module: sr_dmem

---
 rtl/sr_dmem.sv | 254 +++++++++++++++++++++++++
 tb/tb_sr_dmem.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_dmem.sv
// -----------------------------------------------------------------------------
// sr_dmem : single-ported byte-addressable data memory for a small scalar core.
//
// DEPTH bytes arranged as DEPTH/4 32-bit words with four byte lanes. One
// request is accepted per cycle via a valid/ready handshake. Each accepted
// request produces one response strobe in the following cycle.
//
// Build option:
//   SR_DMEM_MISALIGN_EN  defined   -> accesses that straddle a word boundary are
//                                     split over two cycles (IDLE -> SPLIT -> IDLE),
//                                     with the response one cycle later.
//                        undefined -> such accesses are rejected with rsp_err.
//
// Ports:
//   clk        in   single clock, everything moves on the rising edge
//   rst        in   synchronous active-high reset (memory contents untouched)
//   req_valid  in   request present
//   req_ready  out  request can be taken this cycle
//   req_we     in   1 = store, 0 = load
//   req_addr   in   byte address
//   req_wdata  in   store data, LSB-aligned
//   req_size   in   00 byte, 01 half, 10 word, 11 illegal
//   req_sign   in   sign-extend byte/half load results
//   rsp_valid  out  one-cycle response strobe
//   rsp_rdata  out  load result (0 for stores and errors)
//   rsp_err    out  request rejected, qualified by rsp_valid
// -----------------------------------------------------------------------------
module sr_dmem #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int WORDS = DEPTH / 4;
    localparam int IW    = $clog2(WORDS);

    logic [31:0]   mem_q [WORDS];

    logic          accept;
    logic          direct_rsp;
    logic [2:0]    nbytes;
    logic [3:0]    size_mask;
    logic [1:0]    off;
    logic [4:0]    shamt;
    logic [IW-1:0] idx;
    logic [32:0]   last_addr;
    logic          illegal;
    logic          out_of_range;
    logic          misaligned;
    logic          req_error;
    logic          wr_lo;
    logic [3:0]    lo_be;
    logic [31:0]   lo_wdata;
    logic [31:0]   load_data;

    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q,   rsp_err_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;

    // Narrow a right-justified load value to its size and extend it.
    function automatic logic [31:0] extend(input logic [31:0] d,
                                           input logic [1:0]  size,
                                           input logic        sign);
        logic [31:0] r;
        case (size)
            2'b00:   r = {{24{sign & d[7]}},  d[7:0]};
            2'b01:   r = {{16{sign & d[15]}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Pick 32 bits starting at byte 'o' out of a low word plus three bytes
    // of the following word (enough for any access that straddles the edge).
    function automatic logic [31:0] byte_pick(input logic [55:0] dw,
                                              input logic [1:0]  o);
        logic [31:0] r;
        case (o)
            2'd0:    r = dw[31:0];
            2'd1:    r = dw[39:8];
            2'd2:    r = dw[47:16];
            default: r = dw[55:24];
        endcase
        return r;
    endfunction

    // Request decode: access width, lane mask and the error conditions.
    always_comb begin
        nbytes    = 3'd4;
        size_mask = 4'b1111;
        case (req_size)
            2'b00: begin
                nbytes    = 3'd1;
                size_mask = 4'b0001;
            end
            2'b01: begin
                nbytes    = 3'd2;
                size_mask = 4'b0011;
            end
            default: ;
        endcase
    end

    assign off          = req_addr[1:0];
    assign shamt        = {off, 3'b000};
    assign idx          = req_addr[IW+1:2];
    // 33-bit sum so an access near the top of the 32-bit space cannot wrap
    // back into range.
    assign last_addr    = {1'b0, req_addr} + {30'd0, nbytes} - 33'd1;
    assign illegal      = (req_size == 2'b11);
    assign out_of_range = (last_addr >= 33'(DEPTH));
    assign misaligned   = (({1'b0, off} + nbytes - 3'd1) > 3'd3);
    assign accept       = req_valid && req_ready;
    assign wr_lo        = accept && req_we && !req_error;
    assign load_data    = extend(mem_q[idx] >> shamt, req_size, req_sign);

`ifdef SR_DMEM_MISALIGN_EN
    typedef enum logic {
        IDLE,
        SPLIT
    } state_e;

    state_e        state_q, state_d;
    logic          split_req;
    logic [7:0]    be8;
    logic [63:0]   wdata64;
    logic          wr_hi;
    logic [31:0]   split_data;

    logic [31:0]   lo_q;
    logic [1:0]    off_q;
    logic [1:0]    size_q;
    logic          sign_q;
    logic          we_q;
    logic [IW-1:0] hi_idx_q;
    logic [3:0]    hi_be_q;
    logic [31:0]   hi_wdata_q;

    assign req_error  = illegal || out_of_range;
    assign split_req  = misaligned && !req_error;
    assign direct_rsp = accept && !split_req;
    assign req_ready  = !rst && (state_q == IDLE);

    // Lanes and data laid out over a double word; the low half is written at
    // the handshake edge, the high half is held for the SPLIT edge.
    assign be8        = {4'b0000, size_mask} << off;
    assign wdata64    = {32'd0, req_wdata} << shamt;
    assign lo_be      = be8[3:0];
    assign lo_wdata   = wdata64[31:0];
    // Reset during SPLIT abandons the high half of a store.
    assign wr_hi      = (state_q == SPLIT) && we_q && !rst;
    assign split_data = extend(byte_pick({mem_q[hi_idx_q][23:0], lo_q}, off_q),
                               size_q, sign_q);

    // Context of a split access, captured at its handshake edge.
    always_ff @(posedge clk) begin
        if (accept && split_req) begin
            lo_q       <= mem_q[idx];
            off_q      <= off;
            size_q     <= req_size;
            sign_q     <= req_sign;
            we_q       <= req_we;
            hi_idx_q   <= idx + IW'(1);
            hi_be_q    <= be8[7:4];
            hi_wdata_q <= wdata64[63:32];
        end
    end
`else
    assign req_error  = illegal || out_of_range || misaligned;
    assign direct_rsp = accept;
    assign req_ready  = !rst;
    assign lo_be      = size_mask << off;
    assign lo_wdata   = req_wdata << shamt;
`endif

    // Next-state and next-response computation.
    always_comb begin
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        if (direct_rsp) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = req_error;
            if (!req_we && !req_error) begin
                rsp_rdata_d = load_data;
            end
        end
`ifdef SR_DMEM_MISALIGN_EN
        state_d = state_q;
        if (state_q == SPLIT) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            if (!we_q) begin
                rsp_rdata_d = split_data;
            end
        end else if (accept && split_req) begin
            state_d = SPLIT;
        end
`endif
    end

    // Control state and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef SR_DMEM_MISALIGN_EN
            state_q     <= IDLE;
`endif
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
`ifdef SR_DMEM_MISALIGN_EN
            state_q     <= state_d;
`endif
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Byte-lane writes; storage has no reset.
    always_ff @(posedge clk) begin
        if (wr_lo) begin
            if (lo_be[0]) mem_q[idx][7:0]   <= lo_wdata[7:0];
            if (lo_be[1]) mem_q[idx][15:8]  <= lo_wdata[15:8];
            if (lo_be[2]) mem_q[idx][23:16] <= lo_wdata[23:16];
            if (lo_be[3]) mem_q[idx][31:24] <= lo_wdata[31:24];
        end
`ifdef SR_DMEM_MISALIGN_EN
        if (wr_hi) begin
            if (hi_be_q[0]) mem_q[hi_idx_q][7:0]   <= hi_wdata_q[7:0];
            if (hi_be_q[1]) mem_q[hi_idx_q][15:8]  <= hi_wdata_q[15:8];
            if (hi_be_q[2]) mem_q[hi_idx_q][23:16] <= hi_wdata_q[23:16];
            if (hi_be_q[3]) mem_q[hi_idx_q][31:24] <= hi_wdata_q[31:24];
        end
`endif
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sr_dmem.sv
// -----------------------------------------------------------------------------
// tb_sr_dmem : directed self-checking bench for sr_dmem (DEPTH = 1024).
// Expectations follow the SR_DMEM_MISALIGN_EN setting the bench is built with.
// -----------------------------------------------------------------------------
module tb_sr_dmem;

    localparam int DEPTH = 1024;
`ifdef SR_DMEM_MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif
    localparam int SLAT = MIS ? 2 : 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_sign;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    sr_dmem #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_size  (req_size),
        .req_sign  (req_sign),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Present one request at a falling edge and hold it through the
    // handshake edge.
    task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [1:0] size,
                                 input logic sign);
        int guard;
        @(negedge clk);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_size  = size;
        req_sign  = sign;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("ready_before_req", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Wait (bounded) for the response strobe; lat = 0 means none arrived.
    task automatic waitResponse(output int lat, output logic readyAfter,
                                output logic [31:0] rdata, output logic err);
        lat        = 0;
        readyAfter = 1'b0;
        rdata      = '0;
        err        = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) readyAfter = req_ready;
            if (rsp_valid) begin
                lat   = i;
                rdata = rsp_rdata;
                err   = rsp_err;
                break;
            end
        end
    endtask

    task automatic doAccess(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] size,
                            input logic sign, input logic [31:0] expRdata,
                            input logic expErr, input int expLat);
        int          lat;
        logic        readyAfter;
        logic [31:0] rdata;
        logic        err;
        applyStimulus(we, addr, wdata, size, sign);
        waitResponse(lat, readyAfter, rdata, err);
        checkOutput({tag, "_lat"},   32'(lat),        32'(expLat));
        checkOutput({tag, "_rdata"}, rdata,           expRdata);
        checkOutput({tag, "_err"},   32'(err),        32'(expErr));
        checkOutput({tag, "_ready"}, 32'(readyAfter), 32'(expLat == 1));
        @(negedge clk);
        checkOutput({tag, "_strobe"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_size  = 2'b10;
        req_sign  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rdata", rsp_rdata,      32'd0);
        checkOutput("rst_err",   32'(rsp_err),   32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_ready", 32'(req_ready), 32'd1);

        // Word store/load
        doAccess("st_w10", 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b0, 1);
        doAccess("ld_w10", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 1);

        // Byte store with lane isolation, signed/unsigned byte and half loads
        doAccess("st_w20",  1'b1, 32'h20, 32'hA5A5A5A5, 2'b10, 1'b0, 32'h0, 1'b0, 1);
        doAccess("st_b21",  1'b1, 32'h21, 32'h12345680, 2'b00, 1'b0, 32'h0, 1'b0, 1);
        doAccess("ld_b21s", 1'b0, 32'h21, 32'h0, 2'b00, 1'b1, 32'hFFFFFF80, 1'b0, 1);
        doAccess("ld_b21u", 1'b0, 32'h21, 32'h0, 2'b00, 1'b0, 32'h00000080, 1'b0, 1);
        doAccess("ld_w20",  1'b0, 32'h20, 32'h0, 2'b10, 1'b1, 32'hA5A580A5, 1'b0, 1);
        doAccess("ld_h22s", 1'b0, 32'h22, 32'h0, 2'b01, 1'b1, 32'hFFFFA5A5, 1'b0, 1);
        doAccess("ld_h20u", 1'b0, 32'h20, 32'h0, 2'b01, 1'b0, 32'h000080A5, 1'b0, 1);

        // Word store straddling 0x0C/0x10
        doAccess("st_w0c", 1'b1, 32'h0C, 32'hCCCCCCCC, 2'b10, 1'b0, 32'h0, 1'b0, 1);
        doAccess("st_w10b", 1'b1, 32'h10, 32'hDDDDDDDD, 2'b10, 1'b0, 32'h0, 1'b0, 1);
        doAccess("st_w0e", 1'b1, 32'h0E, 32'h11223344, 2'b10, 1'b0, 32'h0, !MIS, SLAT);
        doAccess("ld_w0e", 1'b0, 32'h0E, 32'h0, 2'b10, 1'b0,
                 MIS ? 32'h11223344 : 32'h0, !MIS, SLAT);
        doAccess("ld_w0c", 1'b0, 32'h0C, 32'h0, 2'b10, 1'b0,
                 MIS ? 32'h3344CCCC : 32'hCCCCCCCC, 1'b0, 1);
        doAccess("ld_w10c", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0,
                 MIS ? 32'hDDDD1122 : 32'hDDDDDDDD, 1'b0, 1);

        // Half straddling 0x33/0x34 with sign extension captured at handshake
        doAccess("st_w30", 1'b1, 32'h30, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0, 1);
        doAccess("st_w34", 1'b1, 32'h34, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0, 1);
        doAccess("st_h33", 1'b1, 32'h33, 32'h0000BEEF, 2'b01, 1'b0, 32'h0, !MIS, SLAT);
        doAccess("ld_h33s", 1'b0, 32'h33, 32'h0, 2'b01, 1'b1,
                 MIS ? 32'hFFFFBEEF : 32'h0, !MIS, SLAT);
        doAccess("ld_h33u", 1'b0, 32'h33, 32'h0, 2'b01, 1'b0,
                 MIS ? 32'h0000BEEF : 32'h0, !MIS, SLAT);
        doAccess("ld_w30", 1'b0, 32'h30, 32'h0, 2'b10, 1'b0,
                 MIS ? 32'hEF000000 : 32'h0, 1'b0, 1);
        doAccess("ld_w34", 1'b0, 32'h34, 32'h0, 2'b10, 1'b0,
                 MIS ? 32'h000000BE : 32'h0, 1'b0, 1);

        // Range and size errors, top-of-memory boundary, no wrap-around
        doAccess("st_w0",    1'b1, 32'h0,   32'h01020304, 2'b10, 1'b0, 32'h0, 1'b0, 1);
        doAccess("st_w3fc",  1'b1, 32'h3FC, 32'h0BADF00D, 2'b10, 1'b0, 32'h0, 1'b0, 1);
        doAccess("ld_w3fc",  1'b0, 32'h3FC, 32'h0, 2'b10, 1'b0, 32'h0BADF00D, 1'b0, 1);
        doAccess("ld_b3ff",  1'b0, 32'h3FF, 32'h0, 2'b00, 1'b0, 32'h0000000B, 1'b0, 1);
        doAccess("ld_h3fe",  1'b0, 32'h3FE, 32'h0, 2'b01, 1'b0, 32'h00000BAD, 1'b0, 1);
        doAccess("ld_w3fe",  1'b0, 32'(DEPTH - 2), 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 1);
        doAccess("ld_h3ff",  1'b0, 32'h3FF, 32'h0, 2'b01, 1'b0, 32'h0, 1'b1, 1);
        doAccess("ld_w400",  1'b0, 32'h400, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 1);
        doAccess("ld_wtop",  1'b0, 32'hFFFFFFFC, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 1);
        doAccess("ld_sz3",   1'b0, 32'h0, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 1);
        doAccess("st_sz3",   1'b1, 32'h0, 32'hFFFFFFFF, 2'b11, 1'b0, 32'h0, 1'b1, 1);
        doAccess("st_w400",  1'b1, 32'h400, 32'hFFFFFFFF, 2'b10, 1'b0, 32'h0, 1'b1, 1);
        doAccess("ld_w0",    1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 32'h01020304, 1'b0, 1);

        // Back-to-back store then load to the same word
        doAccess("st_w40", 1'b1, 32'h40, 32'h12345678, 2'b10, 1'b0, 32'h0, 1'b0, 1);
        @(negedge clk);
        req_we    = 1'b1;
        req_addr  = 32'h40;
        req_wdata = 32'hCAFEF00D;
        req_size  = 2'b10;
        req_sign  = 1'b0;
        req_valid = 1'b1;
        @(negedge clk);
        checkOutput("b2b_st_valid", 32'(rsp_valid), 32'd1);
        checkOutput("b2b_st_rdata", rsp_rdata, 32'd0);
        checkOutput("b2b_ld_ready", 32'(req_ready), 32'd1);
        req_we = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("b2b_ld_valid", 32'(rsp_valid), 32'd1);
        checkOutput("b2b_ld_rdata", rsp_rdata, 32'hCAFEF00D);
        checkOutput("b2b_ld_err",   32'(rsp_err), 32'd0);
        @(negedge clk);
        checkOutput("b2b_idle_valid", 32'(rsp_valid), 32'd0);

        // Reset in the middle of a split store
        doAccess("st_w0c_r", 1'b1, 32'h0C, 32'hAAAAAAAA, 2'b10, 1'b0, 32'h0, 1'b0, 1);
        doAccess("st_w10_r", 1'b1, 32'h10, 32'hBBBBBBBB, 2'b10, 1'b0, 32'h0, 1'b0, 1);
        @(negedge clk);
        req_we    = 1'b1;
        req_addr  = 32'h0E;
        req_wdata = 32'h55667788;
        req_size  = 2'b10;
        req_sign  = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("rsplit_ready", 32'(req_ready), 32'(!MIS));
        rst = 1'b1;
        #1;
        checkOutput("rsplit_ready_in_rst", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("rsplit_no_valid", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        doAccess("ld_w0c_r", 1'b0, 32'h0C, 32'h0, 2'b10, 1'b0,
                 MIS ? 32'h7788AAAA : 32'hAAAAAAAA, 1'b0, 1);
        doAccess("ld_w10_r", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hBBBBBBBB, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
